// File: rtl/cnn_layer_accel_pkt_dispatch.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_pkt_dispatch
//
// Splits the inbound network beat stream into packets and routes the payload
// beats to one of four layer-accelerator targets. Each packet starts with a
// header beat that carries the target opcode, a beat count and, for SEQ
// packets, a start write address for the sequencer memory.
//
// Ports
//   network_clk, network_rst_n      clock, async active-low reset
//   from_network_valid/accept       beat handshake (accept is combinational)
//   from_network_payload            beat data / header fields
//   pixel_ready                     pixel target back-pressure
//   datain                          registered payload shared by all targets
//   config_wren, weight_wren,
//   pixel_datain_valid, seq_wren    one-hot write strobes, one cycle after beat
//   seq_wrAddr                      sequencer write address (auto-increment)
//   busy                            high while routing payload beats
//   pkt_done, bad_opcode            one-cycle status pulses
// ---------------------------------------------------------------------------
module cnn_layer_accel_pkt_dispatch #(
    parameter int C_PACKET_WIDTH   = 128,
    parameter int C_SEQ_ADDR_WIDTH = 9,
    parameter int C_LEN_WIDTH      = 16
) (
    input  logic                        network_clk,
    input  logic                        network_rst_n,
    input  logic                        from_network_valid,
    output logic                        from_network_accept,
    input  logic [C_PACKET_WIDTH-1:0]   from_network_payload,
    input  logic                        pixel_ready,
    output logic [C_PACKET_WIDTH-1:0]   datain,
    output logic                        config_wren,
    output logic                        weight_wren,
    output logic                        pixel_datain_valid,
    output logic                        seq_wren,
    output logic [C_SEQ_ADDR_WIDTH-1:0] seq_wrAddr,
    output logic                        busy,
    output logic                        pkt_done,
    output logic                        bad_opcode
);

    localparam logic [3:0] OP_CONFIG = 4'h1;
    localparam logic [3:0] OP_WEIGHT = 4'h2;
    localparam logic [3:0] OP_PIXEL  = 4'h3;
    localparam logic [3:0] OP_SEQ    = 4'h4;

    localparam logic [C_LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [C_LEN_WIDTH-1:0] LEN_ONE  = {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};

    // strobe vector bit positions
    localparam int SB_CONFIG = 0;
    localparam int SB_WEIGHT = 1;
    localparam int SB_PIXEL  = 2;
    localparam int SB_SEQ    = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  op_q, op_d;
    logic [C_LEN_WIDTH-1:0]      cnt_q, cnt_d;
    logic [C_PACKET_WIDTH-1:0]   datain_q, datain_d;
    logic [3:0]                  strb_q, strb_d;
    logic                        done_q, done_d;
    logic                        bad_q, bad_d;
    logic [C_SEQ_ADDR_WIDTH-1:0] addr_q, addr_d;

    // header field decode
    logic [3:0]                  hdr_op;
    logic [C_LEN_WIDTH-1:0]      hdr_len;
    logic [C_SEQ_ADDR_WIDTH-1:0] hdr_addr;
    logic                        hdr_legal;
    logic                        hs;

    assign hdr_op    = from_network_payload[C_PACKET_WIDTH-1 -: 4];
    assign hdr_len   = from_network_payload[C_LEN_WIDTH-1:0];
    assign hdr_addr  = from_network_payload[16 +: C_SEQ_ADDR_WIDTH];
    assign hdr_legal = (hdr_op == OP_CONFIG) || (hdr_op == OP_WEIGHT) ||
                       (hdr_op == OP_PIXEL)  || (hdr_op == OP_SEQ);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        datain_d  = datain_q;
        strb_d    = '0;
        done_d    = 1'b0;
        bad_d     = 1'b0;
        // the address in flight is shown with its strobe, then advances
        addr_d    = strb_q[SB_SEQ] ? addr_q + 1'b1 : addr_q;

        // only the pixel path can stall a payload beat
        from_network_accept = (state_q == S_IDLE) || (op_q != OP_PIXEL) || pixel_ready;
        hs = from_network_valid && from_network_accept;

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (hdr_legal) begin
                        // a new SEQ header overrides any pending increment
                        if (hdr_op == OP_SEQ) addr_d = hdr_addr;
                        if (hdr_len == LEN_ZERO) begin
                            done_d = 1'b1;
                        end else begin
                            op_d    = hdr_op;
                            cnt_d   = hdr_len;
                            state_d = S_DATA;
                        end
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (hs) begin
                    datain_d = from_network_payload;
                    case (op_q)
                        OP_CONFIG: strb_d[SB_CONFIG] = 1'b1;
                        OP_WEIGHT: strb_d[SB_WEIGHT] = 1'b1;
                        OP_PIXEL:  strb_d[SB_PIXEL]  = 1'b1;
                        default:   strb_d[SB_SEQ]    = 1'b1;
                    endcase
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge network_clk or negedge network_rst_n) begin
        if (!network_rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            datain_q <= '0;
            strb_q   <= '0;
            done_q   <= 1'b0;
            bad_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            datain_q <= datain_d;
            strb_q   <= strb_d;
            done_q   <= done_d;
            bad_q    <= bad_d;
            addr_q   <= addr_d;
        end
    end

    assign datain             = datain_q;
    assign config_wren        = strb_q[SB_CONFIG];
    assign weight_wren        = strb_q[SB_WEIGHT];
    assign pixel_datain_valid = strb_q[SB_PIXEL];
    assign seq_wren           = strb_q[SB_SEQ];
    assign seq_wrAddr         = addr_q;
    assign busy               = (state_q == S_DATA);
    assign pkt_done           = done_q;
    assign bad_opcode         = bad_q;

endmodule
